// File: rtl/json_obj_stringify_if.sv
// Field-in / byte-out handshake bundle for the JSON object encoder.
// The master side is the field source and byte sink; the slave side is the encoder.
interface json_obj_stringify_if #(
   parameter int KEY_BYTES = 8,
   parameter int VAL_W     = 32
);
   localparam int LW = $clog2(KEY_BYTES + 1);

   logic                   fld_valid;
   logic                   fld_ready;
   logic [KEY_BYTES*8-1:0] fld_key;
   logic [LW-1:0]          fld_key_len;
   logic [VAL_W-1:0]       fld_val;
   logic                   fld_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_data;
   logic                   out_last;
   logic                   busy;
   logic                   key_trunc;

   modport master (
      output fld_valid, fld_key, fld_key_len, fld_val, fld_last, out_ready,
      input  fld_ready, out_valid, out_data, out_last, busy, key_trunc
   );

   modport slave (
      input  fld_valid, fld_key, fld_key_len, fld_val, fld_last, out_ready,
      output fld_ready, out_valid, out_data, out_last, busy, key_trunc
   );
endinterface

// File: rtl/json_obj_stringify.sv
// JSON object encoder: turns (key, signed value) fields into {"k":v,...} text,
// one ASCII byte per beat; decimal conversion runs while the key is being sent.
module json_obj_stringify #(
   parameter int KEY_BYTES = 8,
   parameter int VAL_W     = 32
) (
   input logic               clk,
   input logic               rst,
   json_obj_stringify_if.slave bus
);
   localparam int unsigned NDIG  = (VAL_W * 301) / 1000 + 1;
   localparam int unsigned BCD_W = NDIG * 4;
   localparam int LW = $clog2(KEY_BYTES + 1);
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int CW = $clog2(VAL_W + 1);

   localparam logic [LW-1:0]    LEN_MAX = LW'(KEY_BYTES);
   localparam logic [LW-1:0]    IDX_ONE = LW'(1);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [CW-1:0]    CNT_ALL = CW'(VAL_W);
   localparam logic [DW-1:0]    DIG_ONE = DW'(1);
   localparam logic [VAL_W-1:0] VAL_ONE = VAL_W'(1);

   typedef enum logic [3:0] {
      S_IDLE, S_OPEN, S_Q1, S_KEY, S_Q2, S_COLON, S_SIGN, S_DIGITS, S_SEP
   } state_t;

   state_t                 state_q, state_d;
   logic [KEY_BYTES*8-1:0] key_q, key_d;
   logic [LW-1:0]          len_q, len_d;
   logic [LW-1:0]          idx_q, idx_d;
   logic                   esc_q, esc_d;
   logic                   neg_q, neg_d;
   logic                   last_q, last_d;
   logic                   busy_q, busy_d;
   logic [VAL_W-1:0]       bin_q, bin_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DW-1:0]          dig_q, dig_d;
   logic                   fld_ready_q, fld_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [7:0]             out_data_q, out_data_d;
   logic                   out_last_q, out_last_d;
   logic                   key_trunc_q, key_trunc_d;

   logic                   accept, fire;
   logic [BCD_W-1:0]       adj;
   logic [7:0]             cur_q_byte, cur_d_byte;

   function automatic logic [7:0] key_byte(input logic [KEY_BYTES*8-1:0] k,
                                           input logic [LW-1:0] i);
      logic [7:0] b;
      b = '0;
      for (int unsigned n = 0; n < KEY_BYTES; n++)
         if (i == LW'(n)) b = k[n*8 +: 8];
      return b;
   endfunction

   function automatic logic needs_esc(input logic [7:0] c);
      return (c == 8'h22) || (c == 8'h5C);
   endfunction

   function automatic logic [DW-1:0] top_digit(input logic [BCD_W-1:0] b);
      logic [DW-1:0] r;
      r = '0;
      for (int unsigned n = 0; n < NDIG; n++)
         if (b[n*4 +: 4] != 4'd0) r = DW'(n);
      return r;
   endfunction

   assign bus.fld_ready = fld_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.key_trunc = key_trunc_q;

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      len_d       = len_q;
      idx_d       = idx_q;
      esc_d       = esc_q;
      neg_d       = neg_q;
      last_d      = last_q;
      busy_d      = busy_q;
      bin_d       = bin_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      dig_d       = dig_q;
      key_trunc_d = 1'b0;
      adj         = bcd_q;
      accept      = (state_q == S_IDLE) && bus.fld_valid && fld_ready_q;
      fire        = out_valid_q && bus.out_ready;
      cur_q_byte  = key_byte(key_q, idx_q);

      // Double-dabble, one bit per clock; the leading-digit index is latched
      // on the final step so DIGITS can start emitting without a search delay.
      if (cnt_q != '0) begin
         for (int unsigned n = 0; n < NDIG; n++)
            if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
         bcd_d = {adj[BCD_W-2:0], bin_q[VAL_W-1]};
         bin_d = {bin_q[VAL_W-2:0], 1'b0};
         cnt_d = cnt_q - CNT_ONE;
         if (cnt_q == CNT_ONE) dig_d = top_digit(bcd_d);
      end

      case (state_q)
         S_IDLE: if (accept) begin
            key_d       = bus.fld_key;
            len_d       = (bus.fld_key_len > LEN_MAX) ? LEN_MAX : bus.fld_key_len;
            key_trunc_d = bus.fld_key_len > LEN_MAX;
            neg_d       = bus.fld_val[VAL_W-1];
            last_d      = bus.fld_last;
            bin_d       = bus.fld_val[VAL_W-1] ? (~bus.fld_val + VAL_ONE) : bus.fld_val;
            bcd_d       = '0;
            cnt_d       = CNT_ALL;
            dig_d       = '0;
            idx_d       = '0;
            esc_d       = 1'b0;
            busy_d      = 1'b1;
            state_d     = busy_q ? S_Q1 : S_OPEN;
         end
         S_OPEN:  if (fire) state_d = S_Q1;
         S_Q1:    if (fire) state_d = (len_q == '0) ? S_Q2 : S_KEY;
         S_KEY: if (fire) begin
            if (needs_esc(cur_q_byte) && !esc_q) begin
               esc_d = 1'b1;
            end else begin
               esc_d = 1'b0;
               idx_d = idx_q + IDX_ONE;
               if (idx_q + IDX_ONE == len_q) state_d = S_Q2;
            end
         end
         S_Q2:    if (fire) state_d = S_COLON;
         S_COLON: if (fire) state_d = neg_q ? S_SIGN : S_DIGITS;
         S_SIGN:  if (fire) state_d = S_DIGITS;
         S_DIGITS: if (fire) begin
            if (dig_q == '0) state_d = S_SEP;
            else             dig_d   = dig_q - DIG_ONE;
         end
         S_SEP: if (fire) begin
            state_d = S_IDLE;
            if (last_q) busy_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered: derive the byte for the state being entered.
      cur_d_byte  = key_byte(key_d, idx_d);
      fld_ready_d = (state_d == S_IDLE);
      out_valid_d = (state_d != S_IDLE) && !((state_d == S_DIGITS) && (cnt_d != '0));
      out_last_d  = (state_d == S_SEP) && last_d;
      case (state_d)
         S_OPEN:       out_data_d = 8'h7B;
         S_Q1, S_Q2:   out_data_d = 8'h22;
         S_KEY:        out_data_d = (!esc_d && needs_esc(cur_d_byte)) ? 8'h5C : cur_d_byte;
         S_COLON:      out_data_d = 8'h3A;
         S_SIGN:       out_data_d = 8'h2D;
         S_DIGITS:     out_data_d = 8'h30 + {4'd0, bcd_d[int'(dig_d)*4 +: 4]};
         S_SEP:        out_data_d = last_d ? 8'h7D : 8'h2C;
         default:      out_data_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         esc_q       <= 1'b0;
         neg_q       <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         bin_q       <= '0;
         bcd_q       <= '0;
         cnt_q       <= '0;
         dig_q       <= '0;
         fld_ready_q <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         key_trunc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         esc_q       <= esc_d;
         neg_q       <= neg_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         bin_q       <= bin_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         dig_q       <= dig_d;
         fld_ready_q <= fld_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         key_trunc_q <= key_trunc_d;
      end
   end
endmodule

// File: tb/tb_json_obj_stringify.sv
// Directed bench for json_obj_stringify: drives fields, collects emitted bytes
// and compares them against hand-written JSON text.
module tb_json_obj_stringify;
   localparam int KEY_BYTES = 8;
   localparam int VAL_W     = 32;
   localparam int LW        = $clog2(KEY_BYTES + 1);

   logic clk;
   logic rst;
   int   errs   = 0;
   int   checks = 0;

   byte  rxq[$];
   bit   lastq[$];
   int   trunc_cnt = 0;
   int   stab_err  = 0;
   bit   stab_en   = 0;
   bit   rand_rdy  = 0;
   logic       pv, prdy, pl;
   logic [7:0] pd;

   json_obj_stringify_if #(.KEY_BYTES(KEY_BYTES), .VAL_W(VAL_W)) bus ();

   json_obj_stringify #(.KEY_BYTES(KEY_BYTES), .VAL_W(VAL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Inputs change 1 time unit after posedge, so the negedge view equals
   // what the DUT will see at the next posedge.
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         rxq.push_back(bus.out_data);
         lastq.push_back(bus.out_last);
      end
      if (!rst && bus.key_trunc) trunc_cnt++;
      if (stab_en && pv && !prdy)
         if (!(bus.out_valid && bus.out_data == pd && bus.out_last == pl)) stab_err++;
      pv   = bus.out_valid;
      prdy = bus.out_ready;
      pd   = bus.out_data;
      pl   = bus.out_last;
   end

   task automatic send_field(input logic [KEY_BYTES*8-1:0] key, input int len,
                             input logic [VAL_W-1:0] val, input bit last);
      bit done = 0;
      @(posedge clk); #1;
      bus.fld_valid   = 1'b1;
      bus.fld_key     = key;
      bus.fld_key_len = LW'(len);
      bus.fld_val     = val;
      bus.fld_last    = last;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         if (bus.fld_ready) begin
            @(posedge clk); #1;
            done = 1;
         end
      end
      bus.fld_valid = 1'b0;
      checks++;
      assert (done) else begin
         errs++;
         $error("FAIL accept_timeout observed=%0d expected=1", done);
      end
   endtask

   task automatic wait_bytes(input int n);
      int i = 0;
      while (rxq.size() < n && i < 3000) begin
         @(negedge clk);
         i++;
      end
      repeat (6) @(negedge clk);
   endtask

   task automatic check_obj(input string tag, input string exp);
      string got = "";
      bit    ok;
      int    nlast = 0;
      wait_bytes(exp.len());
      foreach (rxq[i]) got = $sformatf("%s%c", got, rxq[i]);
      ok = (rxq.size() == exp.len());
      if (ok) foreach (rxq[i]) if (rxq[i] != exp.getc(i)) ok = 0;
      checks++;
      assert (ok) else begin
         errs++;
         $error("FAIL %s observed=%s expected=%s", tag, got, exp);
      end
      foreach (lastq[i]) if (lastq[i]) nlast++;
      checks++;
      assert (nlast == 1 && lastq.size() > 0 && lastq[lastq.size()-1] == 1'b1) else begin
         errs++;
         $error("FAIL %s_last observed=%0d_flags expected=1_on_final", tag, nlast);
      end
      rxq.delete();
      lastq.delete();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.fld_valid   = 1'b0;
      bus.fld_key     = '0;
      bus.fld_key_len = '0;
      bus.fld_val     = '0;
      bus.fld_last    = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_fld_ready", 32'(bus.fld_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_key_trunc", 32'(bus.key_trunc), 32'd0);

      // single field, zero value
      send_field(64'h61, 1, 32'd0, 1'b1);
      check_obj("obj_a0", "{\"a\":0}");
      chk("busy_after_obj", 32'(bus.busy), 32'd0);
      chk("no_trunc_yet", 32'(trunc_cnt), 32'd0);

      // two fields, negative then positive
      send_field(64'h78, 1, -32'sd123, 1'b0);
      chk("busy_field1", 32'(bus.busy), 32'd1);
      send_field(64'h7A79, 2, 32'd45, 1'b1);
      chk("busy_field2", 32'(bus.busy), 32'd1);
      check_obj("obj_two", "{\"x\":-123,\"yz\":45}");
      chk("busy_cleared", 32'(bus.busy), 32'd0);

      // value extremes
      send_field(64'h6B, 1, 32'h8000_0000, 1'b1);
      check_obj("obj_min", "{\"k\":-2147483648}");
      send_field(64'h6B, 1, 32'h7FFF_FFFF, 1'b1);
      check_obj("obj_max", "{\"k\":2147483647}");

      // escaping and key clamping
      send_field(64'h5C62_2261, 4, 32'd7, 1'b1);
      check_obj("obj_esc", "{\"a\\\"b\\\\\":7}");
      send_field("HGFEDCBA", KEY_BYTES + 3, 32'd1, 1'b1);
      check_obj("obj_clamp", "{\"ABCDEFGH\":1}");
      chk("trunc_pulses", 32'(trunc_cnt), 32'd1);

      // empty key
      send_field(64'h0, 0, 32'd10, 1'b1);
      check_obj("obj_empty_key", "{\"\":10}");

      // back-pressure
      stab_en  = 1;
      rand_rdy = 1;
      send_field(64'h78, 1, -32'sd123, 1'b0);
      send_field(64'h7A79, 2, 32'd45, 1'b1);
      check_obj("obj_stall", "{\"x\":-123,\"yz\":45}");
      rand_rdy = 0;
      stab_en  = 0;
      @(posedge clk); #1 bus.out_ready = 1'b1;
      chk("stall_stable", 32'(stab_err), 32'd0);

      // reset while the key is being emitted
      send_field("dcba", 4, 32'd5, 1'b0);
      wait_bytes(3);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_busy",      32'(bus.busy),      32'd0);
      chk("midrst_ready",     32'(bus.fld_ready), 32'd1);
      rst = 1'b0;
      rxq.delete();
      lastq.delete();
      send_field(64'h71, 1, 32'd3, 1'b1);
      check_obj("obj_after_rst", "{\"q\":3}");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
